// File: rtl/seq_adder_if.sv
// Handshake and operand/result bundle for the multi-cycle adder/subtractor.
// The master drives the operation request; the slave (the adder) returns status and result.
interface seq_adder_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/seq_adder.sv
// Multi-cycle ripple adder/subtractor: DIGIT bits per clock from the LSB,
// start/busy/done handshake, carry-out and signed-overflow reporting.
module seq_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    seq_adder_if.slave  bus
);
    localparam int N  = (DIGIT > 0) ? (WIDTH / DIGIT) : 1;
    localparam int CW = $clog2(N + 1);

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
            $error("seq_adder: DIGIT must be >= 1 and divide WIDTH exactly");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] opa_r;
    logic [WIDTH-1:0] opb_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH-1:0] res_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    logic [DIGIT:0]   chain_s;
    logic [DIGIT-1:0] slice_s;
    logic [WIDTH-1:0] res_next_s;

    // Ripple one DIGIT-wide slice and pre-shift its sum bits into the result top.
    always_comb begin
        chain_s    = {(DIGIT+1){1'b0}};
        slice_s    = {DIGIT{1'b0}};
        chain_s[0] = carry_r;
        for (int i = 0; i < DIGIT; i++) begin
            slice_s[i]   = opa_r[i] ^ opb_r[i] ^ chain_s[i];
            chain_s[i+1] = (opa_r[i] & opb_r[i]) | (chain_s[i] & (opa_r[i] ^ opb_r[i]));
        end
        res_next_s = res_r >> DIGIT;
        res_next_s[WIDTH-1 -: DIGIT] = slice_s;
    end

    // Control FSM and datapath registers; outputs are registered and held until the next DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            opa_r   <= {WIDTH{1'b0}};
            opb_r   <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            res_r   <= {WIDTH{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        opa_r   <= bus.a;
                        opb_r   <= bus.sub ? ~bus.b : bus.b;
                        carry_r <= bus.sub ? 1'b1 : bus.cin;
                        cnt_r   <= {CW{1'b0}};
                        res_r   <= {WIDTH{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    opa_r   <= opa_r >> DIGIT;
                    opb_r   <= opb_r >> DIGIT;
                    res_r   <= res_next_s;
                    carry_r <= chain_s[DIGIT];
                    cnt_r   <= cnt_r + CW'(1);
                    // Last slice holds the MSB, so its top two carries give signed overflow.
                    if (cnt_r == CW'(N - 1)) begin
                        sum_r   <= res_next_s;
                        cout_r  <= chain_s[DIGIT];
                        ovf_r   <= chain_s[DIGIT-1] ^ chain_s[DIGIT];
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        state_r <= RUN;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_seq_adder.sv
// Self-checking bench for seq_adder: directed handshake/reset scenarios plus randomized
// operations on several WIDTH/DIGIT configurations against a timeline/arithmetic model.
module tb_seq_adder;
    logic clk = 1'b0;
    logic rst_d = 1'b1;
    logic rst_r = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   rand_done = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Golden result {ovf, cout, sum} for a w-bit operation, from plain integer arithmetic.
    function automatic logic [17:0] golden(input int w, input logic [15:0] a, input logic [15:0] b,
                                           input logic c, input logic s);
        logic [16:0] mask, bb, full;
        logic        co, ov;
        mask = (17'd1 << w) - 17'd1;
        bb   = s ? (~{1'b0, b} & mask) : ({1'b0, b} & mask);
        full = ({1'b0, a} & mask) + bb + (s ? 17'd1 : {16'd0, c});
        co   = full[w];
        ov   = (a[w-1] == bb[w-1]) && (full[w-1] != a[w-1]);
        return {ov, co, full[15:0] & mask[15:0]};
    endfunction

    // ---------------- directed instances ----------------
    seq_adder_if #(.WIDTH(8)) ifd1 ();
    seq_adder_if #(.WIDTH(8)) ifd4 ();
    seq_adder #(.WIDTH(8), .DIGIT(1)) dut_d1 (.clk(clk), .rst(rst_d), .bus(ifd1.slave));
    seq_adder #(.WIDTH(8), .DIGIT(4)) dut_d4 (.clk(clk), .rst(rst_d), .bus(ifd4.slave));

    task automatic check_d1(input string tag, input logic eb, input logic ed,
                            input logic [7:0] es, input logic ec, input logic eo);
        check({tag, ".busy"}, 32'(ifd1.busy), 32'(eb));
        check({tag, ".done"}, 32'(ifd1.done), 32'(ed));
        check({tag, ".sum"},  32'(ifd1.sum),  32'(es));
        check({tag, ".cout"}, 32'(ifd1.cout), 32'(ec));
        check({tag, ".ovf"},  32'(ifd1.ovf),  32'(eo));
    endtask

    task automatic run_d1(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic s,
                          input logic [7:0] es, input logic ec, input logic eo);
        @(negedge clk);
        ifd1.a = a; ifd1.b = b; ifd1.cin = c; ifd1.sub = s; ifd1.start = 1'b1;
        @(negedge clk);
        ifd1.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check({tag, ".busy"}, 32'(ifd1.busy), 32'd1);
            check({tag, ".nodone"}, 32'(ifd1.done), 32'd0);
            @(negedge clk);
        end
        check_d1(tag, 1'b0, 1'b1, es, ec, eo);
    endtask

    initial begin
        int pulses;
        ifd1.start = 1'b0; ifd1.a = 8'h00; ifd1.b = 8'h00; ifd1.cin = 1'b0; ifd1.sub = 1'b0;
        ifd4.start = 1'b0; ifd4.a = 8'h00; ifd4.b = 8'h00; ifd4.cin = 1'b0; ifd4.sub = 1'b0;

        check("pin_3c5a",  32'(golden(8,  16'h003C, 16'h005A, 1'b0, 1'b0)), 32'h20096);
        check("pin_ff01",  32'(golden(8,  16'h00FF, 16'h0001, 1'b1, 1'b0)), 32'h10001);
        check("pin_80m01", 32'(golden(8,  16'h0080, 16'h0001, 1'b0, 1'b1)), 32'h3007F);
        check("pin_w5",    32'(golden(5,  16'h001F, 16'h001F, 1'b1, 1'b0)), 32'h1001F);
        check("pin_w16",   32'(golden(16, 16'h7FFF, 16'h0001, 1'b0, 1'b0)), 32'h28000);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_d1("reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        rst_d = 1'b0;
        rst_r = 1'b0;

        run_d1("t1_add",  8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        run_d1("t2_wrap", 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        run_d1("t2_sub",  8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);

        // DIGIT=4: two RUN cycles, done on the third cycle after start
        @(negedge clk);
        ifd4.a = 8'h80; ifd4.b = 8'h01; ifd4.cin = 1'b0; ifd4.sub = 1'b1; ifd4.start = 1'b1;
        @(negedge clk);
        ifd4.start = 1'b0;
        check("t3.busy1", 32'(ifd4.busy), 32'd1);
        check("t3.done1", 32'(ifd4.done), 32'd0);
        @(negedge clk);
        check("t3.busy2", 32'(ifd4.busy), 32'd1);
        check("t3.done2", 32'(ifd4.done), 32'd0);
        @(negedge clk);
        check("t3.done3", 32'(ifd4.done), 32'd1);
        check("t3.sum",   32'(ifd4.sum),  32'h7F);
        check("t3.cout",  32'(ifd4.cout), 32'd1);
        check("t3.ovf",   32'(ifd4.ovf),  32'd1);

        // start mid-RUN is ignored; start in the DONE cycle chains the next op
        @(negedge clk);
        ifd1.a = 8'h3C; ifd1.b = 8'h5A; ifd1.cin = 1'b0; ifd1.sub = 1'b0; ifd1.start = 1'b1;
        @(negedge clk);
        ifd1.start = 1'b0;
        repeat (2) @(negedge clk);
        ifd1.a = 8'h11; ifd1.b = 8'h22; ifd1.cin = 1'b1; ifd1.sub = 1'b1; ifd1.start = 1'b1;
        @(negedge clk);
        ifd1.start = 1'b0;
        repeat (5) @(negedge clk);
        check_d1("t4_first", 1'b0, 1'b1, 8'h96, 1'b0, 1'b1);
        ifd1.a = 8'hFF; ifd1.b = 8'h01; ifd1.cin = 1'b1; ifd1.sub = 1'b0; ifd1.start = 1'b1;
        @(negedge clk);
        ifd1.start = 1'b0;
        check("t4_b2b.busy", 32'(ifd1.busy), 32'd1);
        repeat (7) @(negedge clk);
        check_d1("t4_hold", 1'b1, 1'b0, 8'h96, 1'b0, 1'b1);
        @(negedge clk);
        check_d1("t4_second", 1'b0, 1'b1, 8'h01, 1'b1, 1'b0);

        // reset during RUN cycle 4 aborts the operation
        @(negedge clk);
        ifd1.a = 8'h3C; ifd1.b = 8'h5A; ifd1.cin = 1'b0; ifd1.sub = 1'b0; ifd1.start = 1'b1;
        @(negedge clk);
        ifd1.start = 1'b0;
        repeat (3) @(negedge clk);
        rst_d = 1'b1;
        @(negedge clk);
        rst_d = 1'b0;
        check_d1("t5_abort", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (ifd1.done) pulses++;
        end
        check("t5_nodone", 32'(pulses), 32'd0);
        run_d1("t5_after", 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);

        wait (rand_done == 4);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // ---------------- randomized instances ----------------
    for (genvar g = 0; g < 4; g++) begin : g_rand
        localparam int W = (g == 2) ? 16 : ((g == 3) ? 5 : 8);
        localparam int D = (g == 0) ? 1 : ((g == 1) ? 2 : ((g == 2) ? 4 : 5));
        localparam int N = W / D;

        seq_adder_if #(.WIDTH(W)) ifr ();
        seq_adder #(.WIDTH(W), .DIGIT(D)) dut (.clk(clk), .rst(rst_r), .bus(ifr.slave));

        int          cnt_m = 0;
        int          ops_m = 0;
        logic [17:0] pend_m = 18'd0;
        logic [17:0] exp_m = 18'd0;

        // Timeline model: cycles since acceptance; 1..N busy, N+1 done with new result.
        always @(posedge clk) begin
            if (rst_r) begin
                cnt_m <= 0;
                exp_m <= 18'd0;
            end else if (cnt_m >= 1 && cnt_m <= N) begin
                cnt_m <= cnt_m + 1;
                if (cnt_m == N) begin
                    exp_m <= pend_m;
                    ops_m <= ops_m + 1;
                end
            end else if (ifr.start) begin
                pend_m <= golden(W, 16'(ifr.a), 16'(ifr.b), ifr.cin, ifr.sub);
                cnt_m  <= 1;
            end else begin
                cnt_m <= 0;
            end
        end

        always @(negedge clk) begin
            if (!rst_r) begin
                check($sformatf("r%0d.busy", g), 32'(ifr.busy), 32'(cnt_m >= 1 && cnt_m <= N));
                check($sformatf("r%0d.done", g), 32'(ifr.done), 32'(cnt_m == N + 1));
                check($sformatf("r%0d.sum", g),  32'(ifr.sum),  32'(exp_m[15:0]));
                check($sformatf("r%0d.cout", g), 32'(ifr.cout), 32'(exp_m[16]));
                check($sformatf("r%0d.ovf", g),  32'(ifr.ovf),  32'(exp_m[17]));
            end
        end

        initial begin
            ifr.start = 1'b0; ifr.a = '0; ifr.b = '0; ifr.cin = 1'b0; ifr.sub = 1'b0;
            repeat (4) @(negedge clk);
            for (int cyc = 0; cyc < 20000 && ops_m < 250; cyc++) begin
                ifr.a     = W'($urandom);
                ifr.b     = W'($urandom);
                ifr.cin   = 1'($urandom);
                ifr.sub   = 1'($urandom);
                ifr.start = ($urandom_range(0, 1) == 1);
                @(negedge clk);
            end
            ifr.start = 1'b0;
            check($sformatf("r%0d.ops", g), 32'(ops_m >= 250), 32'd1);
            rand_done++;
        end
    end
endmodule
